// File: rtl/mem_store_16x16.sv
// mem_store_16x16: single-port word memory with self-clearing init, registered read and status flags
module mem_store_16x16 #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              err_coll,
   output logic              err_uninit,
   output logic              err_busy,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  rd_count
);
   typedef enum logic {CLEAR, RUN} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] clr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written;
   logic run, wr_acc, rd_acc;
   assign run    = state == RUN;
   assign wr_acc = run & wr_en;
   assign rd_acc = run & rd_en;
   assign busy   = ~run;
   // state register
   always_ff @(posedge clk)
      state <= reset ? CLEAR : state_nx;
   // leave CLEAR once the last word has been wiped
   always_comb
      state_nx = (state == CLEAR && clr_ptr == ADDR_W'(DEPTH - 1)) ? RUN : state;
   // clear pointer walks every word once per init sequence
   always_ff @(posedge clk)
      if (reset) clr_ptr <= '0;
      else if (!run) clr_ptr <= clr_ptr + ADDR_W'(1);
   // storage and written flags; nothing is stored while reset is asserted
   always_ff @(posedge clk)
      if (!reset) begin
         if (!run) begin
            mem[clr_ptr]     <= '0;
            written[clr_ptr] <= 1'b0;
         end else if (wr_en) begin
            mem[addr]     <= wdata;
            written[addr] <= 1'b1;
         end
      end
   // registered read port, status pulses and saturating counters; read sees pre-write contents
   always_ff @(posedge clk)
      if (reset) begin
         rdata      <= '0;
         rvalid     <= 1'b0;
         err_coll   <= 1'b0;
         err_uninit <= 1'b0;
         err_busy   <= 1'b0;
         wr_count   <= '0;
         rd_count   <= '0;
      end else begin
         rvalid     <= rd_acc;
         err_coll   <= wr_acc & rd_acc;
         err_uninit <= rd_acc & ~written[addr];
         err_busy   <= ~run & (wr_en | rd_en);
         if (rd_acc) rdata <= mem[addr];
         if (wr_acc && wr_count != '1) wr_count <= wr_count + CNT_W'(1);
         if (rd_acc && rd_count != '1) rd_count <= rd_count + CNT_W'(1);
      end
endmodule

// File: tb/tb_mem_store_16x16.sv
// tb_mem_store_16x16: directed and random checks of mem_store_16x16 against a behavioural model
module tb_mem_store_16x16;
   logic        clk = 1'b0;
   logic        reset, wr_en, rd_en;
   logic [3:0]  addr;
   logic [15:0] wdata, rdata, rdata4;
   logic        rvalid, busy, err_coll, err_uninit, err_busy;
   logic        rvalid4, busy4, err_coll4, err_uninit4, err_busy4;
   logic [15:0] wr_count, rd_count;
   logic [3:0]  wr_count4, rd_count4;
   int n_assert = 0, n_fail = 0;
   int clr_left = 0, wc = 0, rc = 0;
   logic [15:0] m_mem [16];
   bit          m_wr [16];
   logic [15:0] e_rdata = 16'h0;
   bit e_rvalid, e_coll, e_unin, e_ebusy;

   always #5 clk = ~clk;

   mem_store_16x16 dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rvalid(rvalid), .busy(busy), .err_coll(err_coll), .err_uninit(err_uninit),
      .err_busy(err_busy), .wr_count(wr_count), .rd_count(rd_count));

   mem_store_16x16 #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
      .rdata(rdata4), .rvalid(rvalid4), .busy(busy4), .err_coll(err_coll4), .err_uninit(err_uninit4),
      .err_busy(err_busy4), .wr_count(wr_count4), .rd_count(rd_count4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit rst, input bit w, input bit r, input logic [3:0] a, input logic [15:0] d);
      reset = rst; wr_en = w; rd_en = r; addr = a; wdata = d;
      @(posedge clk);
      #1;
      e_rvalid = 0; e_coll = 0; e_unin = 0; e_ebusy = 0;
      if (rst) begin
         clr_left = 16; wc = 0; rc = 0; e_rdata = 16'h0;
         for (int i = 0; i < 16; i++) begin m_mem[i] = 16'h0; m_wr[i] = 0; end
      end else if (clr_left > 0) begin
         e_ebusy = w | r;
         clr_left--;
      end else begin
         e_rvalid = r;
         e_coll = w & r;
         e_unin = r & !m_wr[a];
         if (r) e_rdata = m_mem[a];
         if (w) begin m_mem[a] = d; m_wr[a] = 1; wc++; end
         if (r) rc++;
      end
      chk("busy", busy, clr_left > 0);
      chk("rvalid", rvalid, e_rvalid);
      chk("rdata", rdata, e_rdata);
      chk("err_coll", err_coll, e_coll);
      chk("err_uninit", err_uninit, e_unin);
      chk("err_busy", err_busy, e_ebusy);
      chk("wr_count", wr_count, wc > 65535 ? 65535 : wc);
      chk("rd_count", rd_count, rc > 65535 ? 65535 : rc);
      chk("wr_count_sat4", wr_count4, wc > 15 ? 15 : wc);
      chk("rd_count_sat4", rd_count4, rc > 15 ? 15 : rc);
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 3, 16'hAAAA);
      // init with a write held on from the first cycle
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 3, 16'hAAAA);
      cyc(0, 0, 1, 3, 0);
      chk("t1_uninit_data", rdata, 16'h0000);
      chk("t1_uninit_flag", err_uninit, 1);
      chk("t1_wr_count", wr_count, 0);
      // write then read
      cyc(0, 1, 0, 5, 16'h1234);
      cyc(0, 0, 1, 5, 0);
      chk("t2_rdata", rdata, 16'h1234);
      chk("t2_counts", {wr_count, rd_count}, {16'd1, 16'd2});
      // collision returns old data
      cyc(0, 1, 0, 15, 16'hBEEF);
      cyc(0, 1, 1, 15, 16'h0001);
      chk("t3_coll_old", rdata, 16'hBEEF);
      chk("t3_coll_flag", err_coll, 1);
      cyc(0, 0, 1, 15, 0);
      chk("t3_new", rdata, 16'h0001);
      // fill and back-to-back readback
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 4'(i), 16'(i * 16'h1111));
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1, 4'(i), 0);
         chk("t4_seq", {15'h0, rvalid, rdata}, {15'h0, 1'b1, 16'(i * 16'h1111)});
      end
      cyc(0, 0, 0, 0, 0);
      chk("t4_idle_hold", rdata, 16'hFFFF);
      // reset right after a read
      cyc(0, 0, 1, 7, 0);
      cyc(1, 0, 0, 0, 0);
      chk("t5_rst_rvalid", rvalid, 0);
      chk("t5_rst_rdata", rdata, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 7, 0);
      chk("t5_reread", {err_uninit, rdata}, {1'b1, 16'h0});
      // saturation of the narrow counter
      for (int i = 0; i < 20; i++) cyc(0, 1, 0, 4'(i), 16'(i));
      chk("t6_sat", wr_count4, 4'd15);
      chk("t6_wide", wr_count, 16'd20);
      // random traffic with occasional resets
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             4'($urandom), 16'($urandom));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
